// File: rtl/bcd_pkg.sv
// Shared constants for the sequential binary-to-BCD converter: FSM encoding,
// BCD digit width and the double-dabble add-3 threshold.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] ADD3_TH = 4'd5;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more.
// Combinational, zero latency, no flow control.
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] d_i,
  output logic [BCD_W-1:0] d_o
);

  assign d_o = (d_i >= ADD3_TH) ? d_i + BCD_W'(3) : d_i;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one shift per clock; done BIN_W+1 clocks after start.
// No backpressure: start is ignored (not queued) while busy. Define SIGNED_EN for two's-complement input.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [BIN_W-1:0]         bin_in,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [BCD_W*DIGITS-1:0]  bcd_out,
  output logic                     neg
);

  localparam int CNT_W   = $clog2(BIN_W + 1);
  localparam int BCD_TOT = BCD_W * DIGITS;

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   bin_sr_q, bin_sr_d;
  logic [BCD_TOT-1:0] bcd_sr_q, bcd_sr_d;
  logic [BCD_TOT-1:0] bcd_corr;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sign_q, sign_d;
  logic               done_q, done_d;
  logic [BCD_TOT-1:0] bcd_out_q, bcd_out_d;
  logic               neg_q, neg_d;
  logic               in_sign;
  logic [BIN_W-1:0]   in_mag;

`ifdef SIGNED_EN
  // -32768 negates to itself, which read as unsigned is the wanted 32768.
  assign in_sign = bin_in[BIN_W-1];
  assign in_mag  = in_sign ? -bin_in : bin_in;
`else
  assign in_sign = 1'b0;
  assign in_mag  = bin_in;
`endif

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .d_i (bcd_sr_q[g*BCD_W +: BCD_W]),
      .d_o (bcd_corr[g*BCD_W +: BCD_W])
    );
  end

  always_comb begin
    state_d   = state_q;
    bin_sr_d  = bin_sr_q;
    bcd_sr_d  = bcd_sr_q;
    cnt_d     = cnt_q;
    sign_d    = sign_q;
    done_d    = 1'b0;
    bcd_out_d = bcd_out_q;
    neg_d     = neg_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          bin_sr_d = in_mag;
          bcd_sr_d = '0;
          cnt_d    = CNT_W'(BIN_W);
          sign_d   = in_sign;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_sr_d, bin_sr_d} = {bcd_corr, bin_sr_q} << 1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = FINISH;
      end
      FINISH: begin
        bcd_out_d = bcd_sr_q;
        neg_d     = sign_q;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      bin_sr_q  <= '0;
      bcd_sr_q  <= '0;
      cnt_q     <= '0;
      sign_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_out_q <= '0;
      neg_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_sr_q  <= bin_sr_d;
      bcd_sr_q  <= bcd_sr_d;
      cnt_q     <= cnt_d;
      sign_q    <= sign_d;
      done_q    <= done_d;
      bcd_out_q <= bcd_out_d;
      neg_q     <= neg_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign bcd_out = bcd_out_q;
  assign neg     = neg_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq (default BIN_W=16, DIGITS=5).
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        rst;
  logic [15:0] bin_in;
  logic        start;
  logic        busy;
  logic        done;
  logic [19:0] bcd_out;
  logic        neg;

  int          passed;
  int          total;
  logic [19:0] last_bcd;

  bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .bin_in  (bin_in),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out),
    .neg     (neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one start at the next edge (edge N) and observes 40 cycles after it.
  // Optionally pulses start again so that it is sampled at edge N+poke_cyc.
  task automatic run_conv(input logic [15:0] v, input int poke_cyc, input logic [15:0] poke_val,
                          input logic [19:0] prev, output int lat, output int busy_cnt,
                          output int done_cnt, output bit hold_ok);
    lat = 0; busy_cnt = 0; done_cnt = 0; hold_ok = 1'b1;
    bin_in = v;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    bin_in = ~v;
    if (busy) busy_cnt++;
    for (int i = 1; i <= 40; i++) begin
      if (i == poke_cyc) begin
        start  = 1'b1;
        bin_in = poke_val;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (lat == 0) lat = i;
      end
      if (lat == 0 && bcd_out !== prev) hold_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else passed++;
    total++; if (bcd_out !== 20'h00000) $display("FAIL reset_bcd: got %h expected 00000", bcd_out); else passed++;
    total++; if (neg !== 1'b0) $display("FAIL reset_neg: got %b expected 0", neg); else passed++;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  // Plain conversion with latency, busy-length, hold and single-done checks.
  task automatic test_value(input string name, input logic [15:0] v,
                            input logic [19:0] exp_bcd, input logic exp_neg);
    int lat, bcnt, dcnt;
    bit hold;
    run_conv(v, 0, 16'h0, last_bcd, lat, bcnt, dcnt, hold);
    total++; if (lat !== 17) $display("FAIL %s_latency: got %0d expected 17", name, lat); else passed++;
    total++; if (bcd_out !== exp_bcd) $display("FAIL %s_bcd: got %h expected %h", name, bcd_out, exp_bcd); else passed++;
    total++; if (neg !== exp_neg) $display("FAIL %s_neg: got %b expected %b", name, neg, exp_neg); else passed++;
    total++; if (dcnt !== 1) $display("FAIL %s_done_count: got %0d expected 1", name, dcnt); else passed++;
    total++; if (bcnt !== 17) $display("FAIL %s_busy_cycles: got %0d expected 17", name, bcnt); else passed++;
    total++; if (hold !== 1'b1) $display("FAIL %s_hold: got %b expected 1", name, hold); else passed++;
    last_bcd = exp_bcd;
  endtask

  task automatic test_ignore_start(input int poke_cyc);
    int lat, bcnt, dcnt;
    bit hold;
    run_conv(16'h3039, poke_cyc, 16'h0001, last_bcd, lat, bcnt, dcnt, hold);
    total++; if (lat !== 17) $display("FAIL ignore%0d_latency: got %0d expected 17", poke_cyc, lat); else passed++;
    total++; if (bcd_out !== 20'h12345) $display("FAIL ignore%0d_bcd: got %h expected 12345", poke_cyc, bcd_out); else passed++;
    total++; if (dcnt !== 1) $display("FAIL ignore%0d_done_count: got %0d expected 1", poke_cyc, dcnt); else passed++;
    total++; if (bcnt !== 17) $display("FAIL ignore%0d_busy_cycles: got %0d expected 17", poke_cyc, bcnt); else passed++;
    total++; if (hold !== 1'b1) $display("FAIL ignore%0d_hold: got %b expected 1", poke_cyc, hold); else passed++;
    last_bcd = 20'h12345;
  endtask

  task automatic test_back_to_back();
    int lat, bcnt, dcnt;
    bit hold;
    // Second start lands on the done cycle (state back in IDLE) and must be accepted.
    run_conv(16'h00FF, 18, 16'h270F, last_bcd, lat, bcnt, dcnt, hold);
    total++; if (lat !== 17) $display("FAIL b2b_latency: got %0d expected 17", lat); else passed++;
    total++; if (dcnt !== 2) $display("FAIL b2b_done_count: got %0d expected 2", dcnt); else passed++;
    total++; if (bcnt !== 34) $display("FAIL b2b_busy_cycles: got %0d expected 34", bcnt); else passed++;
    total++; if (bcd_out !== 20'h09999) $display("FAIL b2b_bcd: got %h expected 09999", bcd_out); else passed++;
    total++; if (hold !== 1'b1) $display("FAIL b2b_hold: got %b expected 1", hold); else passed++;
    last_bcd = 20'h09999;
  endtask

  task automatic test_reset_abort();
    int dcnt, bcnt, lat;
    bit hold;
    bin_in = 16'h3039;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    total++; if (busy !== 1'b1) $display("FAIL abort_busy_before: got %b expected 1", busy); else passed++;
    rst = 1'b0;
    #1;
    total++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL abort_done: got %b expected 0", done); else passed++;
    total++; if (bcd_out !== 20'h00000) $display("FAIL abort_bcd: got %h expected 00000", bcd_out); else passed++;
    total++; if (neg !== 1'b0) $display("FAIL abort_neg: got %b expected 0", neg); else passed++;
    @(posedge clk); #1;
    rst = 1'b1;
    dcnt = 0; bcnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done) dcnt++;
      if (busy) bcnt++;
    end
    total++; if (dcnt !== 0) $display("FAIL abort_no_done: got %0d expected 0", dcnt); else passed++;
    total++; if (bcnt !== 0) $display("FAIL abort_idle: got %0d busy cycles expected 0", bcnt); else passed++;
    last_bcd = 20'h00000;
    run_conv(16'h2710, 0, 16'h0, last_bcd, lat, bcnt, dcnt, hold);
    total++; if (lat !== 17) $display("FAIL after_abort_latency: got %0d expected 17", lat); else passed++;
    total++; if (bcd_out !== 20'h10000) $display("FAIL after_abort_bcd: got %h expected 10000", bcd_out); else passed++;
    total++; if (dcnt !== 1) $display("FAIL after_abort_done_count: got %0d expected 1", dcnt); else passed++;
    last_bcd = 20'h10000;
  endtask

  initial begin
    passed   = 0;
    total    = 0;
    last_bcd = 20'h00000;
    rst      = 1'b0;
    start    = 1'b0;
    bin_in   = 16'h0000;
    test_reset();
    test_value("zero", 16'h0000, 20'h00000, 1'b0);
    test_value("v12345", 16'h3039, 20'h12345, 1'b0);
    test_value("v9999", 16'h270F, 20'h09999, 1'b0);
`ifdef SIGNED_EN
    test_value("neg123", 16'hFF85, 20'h00123, 1'b1);
    test_value("min", 16'h8000, 20'h32768, 1'b1);
    test_value("one", 16'h0001, 20'h00001, 1'b0);
`else
    test_value("max", 16'hFFFF, 20'h65535, 1'b0);
    test_value("v32768", 16'h8000, 20'h32768, 1'b0);
`endif
    test_ignore_start(5);
    test_ignore_start(17);
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
